// File: rtl/axis_ramp_ctrl_if.sv
// Bundles the per-channel control inputs and axis outputs of the ramp controller.
// Latency: none (signal container only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface axis_ramp_ctrl_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic                      clr;
  logic [CHANNELS-1:0]       inc;
  logic [CHANNELS-1:0]       dec;
  logic [CHANNELS-1:0]       spring;
  logic [CHANNELS-1:0]       analog_sel;
  logic [CHANNELS*WIDTH-1:0] analog_in;
  logic [CHANNELS*WIDTH-1:0] value_out;
  logic [CHANNELS-1:0]       at_max;
  logic [CHANNELS-1:0]       at_min;
  logic                      tick;

  // Input decode side: drives requests, observes the axis values.
  modport master (
    output clr, inc, dec, spring, analog_sel, analog_in,
    input  value_out, at_max, at_min, tick
  );

  // Ramp controller side.
  modport slave (
    input  clr, inc, dec, spring, analog_sel, analog_in,
    output value_out, at_max, at_min, tick
  );
endinterface

// File: rtl/axis_ramp_ctrl.sv
// Turns inc/dec buttons (or a clamped analog stick) into saturating per-channel lever values.
// Latency: 1 cycle from sampled inputs (tick cycle, or any cycle in analog mode) to value_out.
// Backpressure: none; inputs are levels sampled every cycle, outputs are always valid.
module axis_ramp_ctrl #(
  parameter int CHANNELS  = 2,
  parameter int WIDTH     = 8,
  parameter int TICK_DIV  = 196850,
  parameter int STEP      = 1,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 254,
  parameter int CENTER    = 128,
  parameter int RESET_VAL = 0
) (
  input logic              clk_sys,
  input logic              RESET_L,
  axis_ramp_ctrl_if.slave  io
);

  // Prescaler width; a divide-by-one still needs a one-bit counter.
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int W1 = WIDTH + 1;

  localparam logic [CW-1:0]    CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] V_RESET  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] V_MIN    = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] V_MAX    = WIDTH'(MAX_VAL);

  // One guard bit above the value width so sums and differences never wrap.
  localparam logic [WIDTH:0] P_MIN  = W1'(MIN_VAL);
  localparam logic [WIDTH:0] P_MAX  = W1'(MAX_VAL);
  localparam logic [WIDTH:0] P_CEN  = W1'(CENTER);
  localparam logic [WIDTH:0] P_STEP = W1'(STEP);

  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             tick_q;
  logic [WIDTH-1:0] val_q [CHANNELS];
  logic [WIDTH-1:0] val_d [CHANNELS];

  // One ramp step for a single channel; inc and dec together cancel out.
  function automatic logic [WIDTH-1:0] ramp_next(
    input logic [WIDTH-1:0] v,
    input logic             up,
    input logic             down,
    input logic             spr
  );
    logic [WIDTH:0] w;
    logic [WIDTH:0] r;
    w = {1'b0, v};
    r = w;
    if (up && !down) begin
      r = ((w + P_STEP) > P_MAX) ? P_MAX : (w + P_STEP);
    end else if (down && !up) begin
      r = (w < (P_MIN + P_STEP)) ? P_MIN : (w - P_STEP);
    end else if (!up && !down && spr) begin
      // Snap to centre when within one step so the value never overshoots.
      if (w > P_CEN) begin
        r = ((w - P_CEN) <= P_STEP) ? P_CEN : (w - P_STEP);
      end else if (w < P_CEN) begin
        r = ((P_CEN - w) <= P_STEP) ? P_CEN : (w + P_STEP);
      end
    end
    return r[WIDTH-1:0];
  endfunction

  // Limit a raw analog sample to the legal axis range.
  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] r;
    r = a;
    if (a < V_MIN) r = V_MIN;
    if (a > V_MAX) r = V_MAX;
    return r;
  endfunction

  // Next prescaler count, wrapping at TICK_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : (cnt_q + 1'b1);
  end

  // Shared prescaler; tick is registered and high while the count sits at its last value.
  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (io.clr) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);
    end
  end

  // Per-channel next value: analog tracks every cycle, ramp moves only on tick.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      val_d[n] = val_q[n];
      if (io.analog_sel[n]) begin
        val_d[n] = clamp(io.analog_in[n*WIDTH +: WIDTH]);
      end else if (tick_q) begin
        val_d[n] = ramp_next(val_q[n], io.inc[n], io.dec[n], io.spring[n]);
      end
    end
  end

  // Axis registers double as the output registers, so analog-to-ramp handover is bumpless.
  always_ff @(posedge clk_sys or negedge RESET_L) begin
    if (!RESET_L) begin
      for (int n = 0; n < CHANNELS; n++) val_q[n] <= V_RESET;
    end else if (io.clr) begin
      for (int n = 0; n < CHANNELS; n++) val_q[n] <= V_RESET;
    end else begin
      for (int n = 0; n < CHANNELS; n++) val_q[n] <= val_d[n];
    end
  end

  assign io.tick = tick_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign io.value_out[g*WIDTH +: WIDTH] = val_q[g];
    assign io.at_max[g] = (val_q[g] == V_MAX);
    assign io.at_min[g] = (val_q[g] == V_MIN);
  end

endmodule

// File: doc/axis_ramp_ctrl.md
Name: axis_ramp_ctrl

Overview:
- Multi-channel digital-to-proportional control generator for arcade cores whose cabinets used analog levers (thrust, throttle, paddle) played with D-pad/keyboard.
- Each channel integrates inc/dec buttons into a WIDTH-bit value at a fixed step rate, with saturation, optional spring-return to centre, and a bumpless per-channel switch to a clamped analog-stick source.
- Sits between the hps_io/keyboard input decode and the game top's analog input ports.

Parameters:
CHANNELS, 2, number of independent axes
WIDTH, 8, bits per axis value
TICK_DIV, 196850, clk_sys cycles per ramp step (>=1)
STEP, 1, value change per tick (>=1)
MIN_VAL, 0, lower saturation limit
MAX_VAL, 254, upper saturation limit
CENTER, 128, spring-return target (MIN_VAL<=CENTER<=MAX_VAL)
RESET_VAL, 0, axis value after reset/clear (MIN_VAL..MAX_VAL)

Ports:
clk_sys  in  1  system clock; single clock domain
RESET_L  in  1  asynchronous active-low reset
clr  in  1  synchronous clear: all axes to RESET_VAL, prescaler to 0
inc  in  CHANNELS  per-channel increase request, level, active-high
dec  in  CHANNELS  per-channel decrease request, level, active-high
spring  in  CHANNELS  per-channel mode: 1 = return to CENTER when idle, 0 = hold
analog_sel  in  CHANNELS  per-channel source: 1 = analog_in, 0 = ramp
analog_in  in  CHANNELS*WIDTH  unsigned analog values, channel n at [n*WIDTH +: WIDTH]
value_out  out  CHANNELS*WIDTH  registered axis values, same packing
at_max  out  CHANNELS  value_out[n] == MAX_VAL
at_min  out  CHANNELS  value_out[n] == MIN_VAL
tick  out  1  one-cycle pulse on each ramp step

Behaviour:
- Reset (RESET_L=0, asynchronous):
  - prescaler = 0; tick = 0.
  - Every axis register and value_out = RESET_VAL.
  - at_max/at_min reflect RESET_VAL.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly the cycle in which the count equals TICK_DIV-1; with TICK_DIV=1, tick is high every cycle.
  - First tick after reset or clr occurs on cycle TICK_DIV.
- clr:
  - Takes priority over all updates in its cycle.
  - Axes = RESET_VAL, prescaler = 0, tick = 0.
- Per-channel ramp update, only on a tick cycle, with analog_sel=0:
  - inc & dec both high: no change.
  - inc only: v = min(v+STEP, MAX_VAL).
  - dec only: v = max(v-STEP, MIN_VAL).
  - Neither, spring=1: move toward CENTER by STEP without overshoot (|v-CENTER| <= STEP gives v = CENTER).
  - Neither, spring=0: hold.
- Arithmetic is done in WIDTH+1 bits so the result never wraps, then saturated.
- Inputs are sampled in the tick cycle; the new value appears on value_out the following cycle (1-cycle latency).
- Analog path (analog_sel=1):
  - Every cycle, value_out = clamp(analog_in, MIN_VAL, MAX_VAL), registered, 1-cycle latency.
  - The axis register is loaded with the same clamped value, so switching back to ramp mode is bumpless.
  - inc/dec/spring are ignored while analog_sel=1.
- analog_sel change: takes effect on the next clock edge; no glitch values, no reset of other channels.
- Channels are fully independent; the prescaler and tick are shared.
- at_max/at_min are combinational compares of registered value_out.
- Inputs are assumed already synchronous to clk_sys; there are no synchronizers inside.

Test Plan:
(Bench config unless stated: TICK_DIV=4, WIDTH=8, STEP=1, MIN 0, MAX 254, CENTER 128, RESET_VAL 0, CHANNELS 2.)
- Release reset, hold inc[0] for 300 ticks -> ch0 increments once per 4 cycles, reaches 254 after 254 ticks and stays; at_max[0]=1 from then; ch1 stays 0.
- ch0 at 10, assert inc[0] & dec[0] for 20 ticks -> value stays 10. dec[0] alone for 15 ticks -> value 0, at_min[0]=1, no wrap to 255.
- Spring, STEP=3: ch0 at 130, spring[0]=1, no buttons -> 128 after one tick, not 127, then constant. From 120 -> 123, 126, 128.
- analog_sel[1]=1, analog_in ch1=255 -> value_out ch1=254 one cycle later. Deselect with inc[1] held -> next tick gives 254 (saturated). Analog 40 then deselect + dec -> 39.
- Assert RESET_L low mid-ramp (value 77) -> value_out 0 immediately, without a clock edge; tick low. After release, the first tick occurs 4 cycles later.
- Pulse clr at prescaler count 2 with axes non-zero -> next cycle all axes 0; the next tick arrives exactly 4 cycles after clr; clr overrides a simultaneous tick and inc.
